// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - one read/write plus one read-only port SRAM with byte masks and zero-init sweep
module sram_1rw1r_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_WMASKS     = DATA_WIDTH / 8,
    parameter int COLLISION_MODE = 0,
    parameter int OUT_REG        = 0,
    parameter int INIT_ZERO      = 1
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  ready,
    output logic                  collision
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc0, acc1, wr0, rd0, col_hit, init_we;
    logic [DATA_WIDTH-1:0]   merged, rd1_word;

    logic                    p_v0, p_v1, p_col;
    logic [DATA_WIDTH-1:0]   p_d0, p_d1;
    logic                    q_v0, q_v1, q_col;
    logic [DATA_WIDTH-1:0]   q_d0, q_d1;

    assign acc0    = ready && !csb0;
    assign acc1    = ready && !csb1;
    assign wr0     = acc0 && !web0;
    assign rd0     = acc0 && web0;
    assign col_hit = wr0 && acc1 && (addr0 == addr1);
    assign init_we = (state == S_INIT) && (INIT_ZERO != 0);

    // Byte-merged word doubles as the write data and the write-first bypass value.
    always_comb begin
        merged = mem[addr0];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) merged[i*8 +: 8] = din0[i*8 +: 8];
        end
    end

    assign rd1_word = (col_hit && (COLLISION_MODE == 0)) ? merged : mem[addr1];

    always_ff @(posedge clk0) begin
        if (init_we)  mem[init_cnt] <= '0;
        else if (wr0) mem[addr0]    <= merged;
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if ((INIT_ZERO == 0) || (init_cnt == {ADDR_WIDTH{1'b1}})) begin
                        state    <= S_RUN;
                        ready    <= 1'b1;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_RUN: ready <= 1'b1;
                default: begin
                    state <= S_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Capture stage: array words are sampled on the accepting edge.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            p_v0  <= 1'b0;
            p_v1  <= 1'b0;
            p_col <= 1'b0;
            p_d0  <= '0;
            p_d1  <= '0;
        end else begin
            p_v0  <= rd0;
            p_v1  <= acc1;
            p_col <= col_hit;
            if (rd0)  p_d0 <= mem[addr0];
            if (acc1) p_d1 <= rd1_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk0 or negedge rst_n) begin
            if (!rst_n) begin
                q_v0  <= 1'b0;
                q_v1  <= 1'b0;
                q_col <= 1'b0;
                q_d0  <= '0;
                q_d1  <= '0;
            end else begin
                q_v0  <= p_v0;
                q_v1  <= p_v1;
                q_col <= p_col;
                if (p_v0) q_d0 <= p_d0;
                if (p_v1) q_d1 <= p_d1;
            end
        end
    end else begin : g_no_out_reg
        assign q_v0  = p_v0;
        assign q_v1  = p_v1;
        assign q_col = p_col;
        assign q_d0  = p_d0;
        assign q_d1  = p_d1;
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            dout0       <= '0;
            dout1       <= '0;
            dout0_valid <= 1'b0;
            dout1_valid <= 1'b0;
            collision   <= 1'b0;
        end else begin
            dout0_valid <= q_v0;
            dout1_valid <= q_v1;
            collision   <= q_col;
            if (q_v0) dout0 <= q_d0;
            if (q_v1) dout1 <= q_d1;
        end
    end
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb/tb_sram_1rw1r_param.sv - scoreboard bench for sram_1rw1r_param over four parameter sets
module tb_sram_1rw1r_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int errors = 0;
    int checks = 0;

    logic        a_csb0, a_web0, a_csb1;
    logic [3:0]  a_wmask0;
    logic [7:0]  a_addr0, a_addr1;
    logic [31:0] a_din0;

    logic [31:0] def_d0, def_d1, rf_d0, rf_d1, or_d0, or_d1;
    logic        def_v0, def_v1, def_rdy, def_col;
    logic        rf_v0, rf_v1, rf_rdy, rf_col;
    logic        or_v0, or_v1, or_rdy, or_col;

    logic        b_csb0, b_web0, b_csb1;
    logic [7:0]  b_wmask0;
    logic [3:0]  b_addr0, b_addr1;
    logic [63:0] b_din0, b_d0, b_d1;
    logic        b_v0, b_v1, b_rdy, b_col;

    sram_1rw1r_param u_def (
        .clk0(clk), .rst_n(rst_n), .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0),
        .addr0(a_addr0), .din0(a_din0), .dout0(def_d0), .dout0_valid(def_v0),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(def_d1), .dout1_valid(def_v1),
        .ready(def_rdy), .collision(def_col));

    sram_1rw1r_param #(.COLLISION_MODE(1)) u_rf (
        .clk0(clk), .rst_n(rst_n), .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0),
        .addr0(a_addr0), .din0(a_din0), .dout0(rf_d0), .dout0_valid(rf_v0),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(rf_d1), .dout1_valid(rf_v1),
        .ready(rf_rdy), .collision(rf_col));

    sram_1rw1r_param #(.OUT_REG(1)) u_or (
        .clk0(clk), .rst_n(rst_n), .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0),
        .addr0(a_addr0), .din0(a_din0), .dout0(or_d0), .dout0_valid(or_v0),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(or_d1), .dout1_valid(or_v1),
        .ready(or_rdy), .collision(or_col));

    sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .INIT_ZERO(0)) u_w64 (
        .clk0(clk), .rst_n(rst_n), .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0),
        .addr0(b_addr0), .din0(b_din0), .dout0(b_d0), .dout0_valid(b_v0),
        .csb1(b_csb1), .addr1(b_addr1), .dout1(b_d1), .dout1_valid(b_v1),
        .ready(b_rdy), .collision(b_col));

    typedef struct {
        logic [63:0] data;
        logic        col;
        int          cyc;
    } exp_t;

    exp_t qd0[$], qd1[$], qr0[$], qr1[$], qo0[$], qo1[$], qb0[$], qb1[$];
    logic [31:0] ma [256];
    logic [63:0] mb [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every cycle: valid must match a due queue entry; data and collision checked on pop.
    exp_t e;
    logic ev;
    always @(negedge clk) begin
        ev = (qd0.size() > 0) && (qd0[0].cyc == cyc_n);
        chk("def_v0", def_v0, ev);
        if (def_v0 && qd0.size() > 0) begin e = qd0.pop_front(); chk("def_d0", def_d0, e.data); end
        ev = (qd1.size() > 0) && (qd1[0].cyc == cyc_n);
        chk("def_v1", def_v1, ev);
        chk("def_col", def_col, ev ? qd1[0].col : 1'b0);
        if (def_v1 && qd1.size() > 0) begin e = qd1.pop_front(); chk("def_d1", def_d1, e.data); end

        ev = (qr0.size() > 0) && (qr0[0].cyc == cyc_n);
        chk("rf_v0", rf_v0, ev);
        if (rf_v0 && qr0.size() > 0) begin e = qr0.pop_front(); chk("rf_d0", rf_d0, e.data); end
        ev = (qr1.size() > 0) && (qr1[0].cyc == cyc_n);
        chk("rf_v1", rf_v1, ev);
        chk("rf_col", rf_col, ev ? qr1[0].col : 1'b0);
        if (rf_v1 && qr1.size() > 0) begin e = qr1.pop_front(); chk("rf_d1", rf_d1, e.data); end

        ev = (qo0.size() > 0) && (qo0[0].cyc == cyc_n);
        chk("or_v0", or_v0, ev);
        if (or_v0 && qo0.size() > 0) begin e = qo0.pop_front(); chk("or_d0", or_d0, e.data); end
        ev = (qo1.size() > 0) && (qo1[0].cyc == cyc_n);
        chk("or_v1", or_v1, ev);
        chk("or_col", or_col, ev ? qo1[0].col : 1'b0);
        if (or_v1 && qo1.size() > 0) begin e = qo1.pop_front(); chk("or_d1", or_d1, e.data); end

        ev = (qb0.size() > 0) && (qb0[0].cyc == cyc_n);
        chk("w64_v0", b_v0, ev);
        if (b_v0 && qb0.size() > 0) begin e = qb0.pop_front(); chk("w64_d0", b_d0, e.data); end
        ev = (qb1.size() > 0) && (qb1[0].cyc == cyc_n);
        chk("w64_v1", b_v1, ev);
        chk("w64_col", b_col, ev ? qb1[0].col : 1'b0);
        if (b_v1 && qb1.size() > 0) begin e = qb1.pop_front(); chk("w64_d1", b_d1, e.data); end
    end

    task automatic drive_a(input logic c0, input logic w0, input logic [3:0] m, input logic [7:0] a0,
                           input logic [31:0] d, input logic c1, input logic [7:0] a1);
        exp_t x;
        logic [31:0] mrg;
        logic col;
        a_csb0 = c0; a_web0 = w0; a_wmask0 = m; a_addr0 = a0; a_din0 = d;
        a_csb1 = c1; a_addr1 = a1;
        mrg = ma[a0];
        for (int i = 0; i < 4; i++) if (m[i]) mrg[i*8 +: 8] = d[i*8 +: 8];
        if (!c0 && w0) begin
            x.data = 64'(ma[a0]); x.col = 1'b0; x.cyc = cyc_n + 2;
            qd0.push_back(x); qr0.push_back(x);
            x.cyc = cyc_n + 3; qo0.push_back(x);
        end
        if (!c1) begin
            col = !c0 && !w0 && (a0 == a1);
            x.col = col; x.data = 64'(col ? mrg : ma[a1]); x.cyc = cyc_n + 2;
            qd1.push_back(x);
            x.cyc = cyc_n + 3; qo1.push_back(x);
            x.data = 64'(ma[a1]); x.cyc = cyc_n + 2; qr1.push_back(x);
        end
        if (!c0 && !w0) ma[a0] = mrg;
        @(posedge clk); #1;
    endtask

    task automatic drive_b(input logic c0, input logic w0, input logic [7:0] m, input logic [3:0] a0,
                           input logic [63:0] d, input logic c1, input logic [3:0] a1);
        exp_t x;
        logic [63:0] mrg;
        logic col;
        b_csb0 = c0; b_web0 = w0; b_wmask0 = m; b_addr0 = a0; b_din0 = d;
        b_csb1 = c1; b_addr1 = a1;
        mrg = mb[a0];
        for (int i = 0; i < 8; i++) if (m[i]) mrg[i*8 +: 8] = d[i*8 +: 8];
        if (!c0 && w0) begin
            x.data = mb[a0]; x.col = 1'b0; x.cyc = cyc_n + 2; qb0.push_back(x);
        end
        if (!c1) begin
            col = !c0 && !w0 && (a0 == a1);
            x.col = col; x.data = col ? mrg : mb[a1]; x.cyc = cyc_n + 2; qb1.push_back(x);
        end
        if (!c0 && !w0) mb[a0] = mrg;
        @(posedge clk); #1;
    endtask

    int n;
    int op;

    initial begin
        rst_n = 1'b0;
        a_csb0 = 1'b1; a_web0 = 1'b1; a_wmask0 = '0; a_addr0 = '0; a_din0 = '0; a_csb1 = 1'b1; a_addr1 = '0;
        b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0; b_addr0 = '0; b_din0 = '0; b_csb1 = 1'b1; b_addr1 = '0;
        for (int i = 0; i < 256; i++) ma[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout0", def_d0, 0);
        chk("rst_dout1", def_d1, 0);
        chk("rst_ready", def_rdy, 0);
        chk("rst_or_ready", or_rdy, 0);
        chk("rst_w64_ready", b_rdy, 0);
        chk("rst_w64_dout0", b_d0, 0);

        // Requests while not ready must be dropped.
        a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'hFF; a_csb1 = 1'b0; a_addr1 = 8'h01;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("w64_ready_one_edge", b_rdy, 1);
        chk("init_ready_low", def_rdy, 0);
        repeat (99) begin @(posedge clk); #1; end
        chk("drop_dout0", def_d0, 0);
        chk("drop_dout1", def_d1, 0);
        chk("init100_ready_low", def_rdy, 0);

        // Reset mid-sweep restarts it from address 0.
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        n = 0;
        while (!def_rdy && n < 300) begin @(posedge clk); #1; n++; end
        a_csb0 = 1'b1; a_csb1 = 1'b1;
        chk("init_cycles", n, 256);
        chk("rf_ready", rf_rdy, 1);
        chk("or_ready", or_rdy, 1);

        drive_a(0, 1, 4'h0, 8'hFF, 32'h0, 1, 8'h0);
        drive_a(0, 0, 4'hF, 8'h10, 32'hAABBCCDD, 1, 8'h0);
        drive_a(0, 0, 4'h5, 8'h10, 32'h11223344, 1, 8'h0);
        drive_a(0, 1, 4'h0, 8'h10, 32'h0, 1, 8'h0);
        drive_a(0, 0, 4'h0, 8'h10, 32'hDEADBEEF, 1, 8'h0);
        drive_a(0, 1, 4'h0, 8'h10, 32'h0, 1, 8'h0);
        drive_a(0, 0, 4'h3, 8'h20, 32'hFFFFFFFF, 0, 8'h20);
        drive_a(1, 1, 4'h0, 8'h0, 32'h0, 0, 8'h20);
        for (int i = 0; i < 4; i++)
            drive_a(0, 0, 4'hF, 8'(i), 32'h1111_0000 * (i + 1) + 32'(i), 0, 8'h10);
        for (int i = 0; i < 4; i++)
            drive_a(0, 1, 4'h0, 8'(i), 32'h0, 0, 8'(3 - i));
        repeat (60) begin
            op = $urandom_range(0, 2);
            drive_a(op == 0, op != 1, 4'($urandom), 8'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) == 0, 8'($urandom_range(0, 7)));
        end
        repeat (4) drive_a(1, 1, 4'h0, 8'h0, 32'h0, 1, 8'h0);

        for (int i = 0; i < 16; i++)
            drive_b(0, 0, 8'hFF, 4'(i), {$urandom, $urandom}, 1, 4'h0);
        repeat (24)
            drive_b(0, 0, 8'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                    0, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 16; i++)
            drive_b(0, 1, 8'h00, 4'(i), 64'h0, 0, 4'(15 - i));
        repeat (3) drive_b(1, 1, 8'h00, 4'h0, 64'h0, 1, 4'h0);

        // A read accepted just before reset must never emerge.
        a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'h10; a_csb1 = 1'b0; a_addr1 = 8'h10;
        @(posedge clk); #1;
        a_csb0 = 1'b1; a_csb1 = 1'b1;
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("inflight_dout0", def_d0, 0);
        chk("inflight_or_dout0", or_d0, 0);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        chk("q_def0_empty", qd0.size(), 0);
        chk("q_def1_empty", qd1.size(), 0);
        chk("q_rf0_empty", qr0.size(), 0);
        chk("q_rf1_empty", qr1.size(), 0);
        chk("q_or0_empty", qo0.size(), 0);
        chk("q_or1_empty", qo1.size(), 0);
        chk("q_w64_0_empty", qb0.size(), 0);
        chk("q_w64_1_empty", qb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter NUM_WMASKS, default DATA_WIDTH/8: one write-mask bit per byte.
REQ-004 The block SHALL have parameter COLLISION_MODE, default 0: 0 selects write-first, 1 selects read-first for a same-address port-1 read.
REQ-005 The block SHALL have parameter OUT_REG, default 0: 1 adds one output pipeline stage to both read ports.
REQ-006 The block SHALL have parameter INIT_ZERO, default 1: 1 clears the array to zero after reset.
REQ-007 The block SHALL have port clk0, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port csb0, input, 1 bit: port 0 active-low chip select.
REQ-010 The block SHALL have port web0, input, 1 bit: port 0 active-low write enable.
REQ-011 The block SHALL have port wmask0, input, NUM_WMASKS bits: byte write enables, active high.
REQ-012 The block SHALL have port addr0, input, ADDR_WIDTH bits: port 0 address.
REQ-013 The block SHALL have port din0, input, DATA_WIDTH bits: port 0 write data.
REQ-014 The block SHALL have port dout0, output, DATA_WIDTH bits: port 0 read data.
REQ-015 The block SHALL have port dout0_valid, output, 1 bit: one-cycle pulse qualifying dout0.
REQ-016 The block SHALL have port csb1, input, 1 bit: port 1 (read-only) active-low chip select.
REQ-017 The block SHALL have port addr1, input, ADDR_WIDTH bits: port 1 address.
REQ-018 The block SHALL have port dout1, output, DATA_WIDTH bits: port 1 read data.
REQ-019 The block SHALL have port dout1_valid, output, 1 bit: one-cycle pulse qualifying dout1.
REQ-020 The block SHALL have port ready, output, 1 bit: high when accesses are accepted.
REQ-021 The block SHALL have port collision, output, 1 bit: one-cycle pulse aligned with dout1_valid, marking a same-address read-during-write.

Function
REQ-022 A request SHALL be accepted on a rising edge only when ready=1 and its csb is 0; requests while ready=0 SHALL be dropped with no memory change and no valid pulse.
REQ-023 A port 0 write (web0=0) SHALL update only bytes with wmask0[i]=1 on the accepting edge; it SHALL produce no dout0_valid; wmask0=0 SHALL leave the word unchanged.
REQ-024 A port 0 read (web0=1) accepted at edge N SHALL drive dout0 and pulse dout0_valid at edge N+1+OUT_REG; port 1 SHALL have the same latency.
REQ-025 dout0 and dout1 SHALL hold their last value when not updated, never X.
REQ-026 A port 1 read of the address written by port 0 on the same edge SHALL return the new byte-merged word if COLLISION_MODE=0, else the pre-write word; collision SHALL pulse with that dout1_valid.
REQ-027 Back-to-back accesses on every cycle SHALL be sustained on both ports with no bubbles.
REQ-028 A port 0 read issued on the edge after a write to the same address SHALL return the written data.
REQ-029 The FSM SHALL have states INIT and RUN, with ready=1 only in RUN.
REQ-030 In INIT, an ADDR_WIDTH-bit counter SHALL write zero to one address per cycle from 0 to 2**ADDR_WIDTH-1, then enter RUN; INIT SHALL take exactly 2**ADDR_WIDTH cycles.
REQ-031 With INIT_ZERO=0, the FSM SHALL enter RUN on the first edge after reset release and array contents SHALL be undefined.
REQ-032 Read pipeline stages in flight at reset SHALL be discarded, producing no valid pulse.

Reset
REQ-033 While rst_n=0, dout0, dout1, dout0_valid, dout1_valid, collision, ready and the init counter SHALL be 0; the array SHALL NOT be reset directly.
REQ-034 After rst_n rises, the FSM SHALL enter INIT if INIT_ZERO=1, else RUN.
REQ-035 Reset asserted mid-INIT SHALL restart the sweep from address 0 after release.

Verification
REQ-036 Defaults, reset released: ready rises after exactly 256 cycles; a port 0 read of addr 0xFF then returns 0x00000000 with dout0_valid one cycle after acceptance.
REQ-037 Write addr 0x10 din 0xAABBCCDD wmask 1111, then write din 0x11223344 wmask 0101, then read addr 0x10 -> 0xAA22CC44.
REQ-038 COLLISION_MODE=0: mem[0x20]=0x0, same-edge port 0 write 0xFFFFFFFF wmask 0011 and port 1 read 0x20 -> dout1=0x0000FFFF, collision=1; with COLLISION_MODE=1 -> dout1=0x0, collision=1.
REQ-039 OUT_REG=1: reads accepted on 4 consecutive edges at addrs 0..3 -> dout0_valid high for 4 consecutive cycles starting 2 edges after the first, with data in order.
REQ-040 Read request while ready=0 -> no dout0_valid and dout0 unchanged; reset pulsed at INIT count 100 -> ready rises 256 cycles after release.
REQ-041 INIT_ZERO=0, DATA_WIDTH=64, ADDR_WIDTH=4 -> ready=1 one edge after release; 8-bit wmask write/readback across all 16 addresses matches the model.
